// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises a raw pin, rejects contact bounce and
// produces a clean level plus one-cycle press/release strobes.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain; only its last stage feeds the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Stability FSM: a level is accepted after STABLE_CYCLES equal samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_LOW;
            r_cnt         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_btn_s) begin
                        r_state <= S_RISE;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                S_RISE: begin
                    if (!w_btn_s) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= S_HIGH;
                        r_cnt       <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!w_btn_s) begin
                        r_state <= S_FALL;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                S_FALL: begin
                    if (w_btn_s) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= S_LOW;
                        r_cnt         <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer against a run-length model
// of the debounced level (SYNC_STAGES=2, STABLE_CYCLES=4).
module tb_button_debouncer;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 4;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int total = 0;
    int bad   = 0;

    button_debouncer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the pin is seen SYNC edges late; a level is accepted once the
    // delayed pin has differed from the current level for STABLE samples in a row.
    bit q_dly[$];
    int m_run;
    bit m_level, m_press, m_rel;

    always @(posedge clk) begin
        if (reset) begin
            q_dly = {};
            for (int i = 0; i < int'(SYNC); i++) q_dly.push_back(1'b0);
            m_run   = 0;
            m_level = 1'b0;
            m_press = 1'b0;
            m_rel   = 1'b0;
        end else begin
            bit d;
            d       = q_dly.pop_front();
            q_dly.push_back(btn_in);
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (d != m_level) begin
                m_run++;
                if (m_run == int'(STABLE)) begin
                    m_level = d;
                    m_press = d;
                    m_rel   = ~d;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // Every-cycle comparison against the model, plus strobe counters.
    bit cmp_en = 1'b0;
    int n_press = 0;
    int n_rel   = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("level", 32'(btn_level), 32'(m_level));
            check("press", 32'(press_pulse), 32'(m_press));
            check("release", 32'(release_pulse), 32'(m_rel));
            if (press_pulse === 1'b1) n_press++;
            if (release_pulse === 1'b1) n_rel++;
        end
    end

    // FFD in toggle configuration, enabled by press_pulse.
    logic ff_q;
    int   n_toggle = 0;
    always @(posedge clk) begin
        if (reset) ff_q <= 1'b0;
        else if (press_pulse) begin
            ff_q <= ~ff_q;
            n_toggle <= n_toggle + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic v);
        btn_in = v;
        repeat (12) tick();
    endtask

    initial begin
        int p0, r0, p_edge, r_edge, hi, rise_at;
        bit ok;
        logic [7:0] pat;

        // 1: button held through reset, fresh press after release
        reset  = 1'b1;
        btn_in = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        check("t1_rst_level", 32'(btn_level), 32'd0);
        check("t1_rst_press", 32'(press_pulse), 32'd0);
        check("t1_rst_release", 32'(release_pulse), 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("t1_level_e5", 32'(btn_level), 32'd0);
        tick();
        check("t1_level_e6", 32'(btn_level), 32'd1);
        check("t1_press_e6", 32'(press_pulse), 32'd1);
        tick();
        check("t1_press_e7", 32'(press_pulse), 32'd0);

        // 2: runs of three highs are all bounce
        settle(1'b0);
        p0  = n_press;
        pat = 8'b1110_1110;
        ok  = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            btn_in = pat[i];
            tick();
            if (btn_level !== 1'b0) ok = 1'b0;
        end
        btn_in = 1'b0;
        repeat (10) begin
            tick();
            if (btn_level !== 1'b0) ok = 1'b0;
        end
        check("t2_level_low", 32'(ok), 32'd1);
        check("t2_no_press", 32'(n_press - p0), 32'd0);

        // 3: clean 20-cycle press
        p0 = n_press; r0 = n_rel; p_edge = 0; r_edge = 0; hi = 0;
        btn_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (press_pulse === 1'b1) p_edge = i;
            if (btn_level === 1'b1) hi++;
        end
        btn_in = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (release_pulse === 1'b1) r_edge = j;
            if (btn_level === 1'b1) hi++;
        end
        check("t3_press_edge", 32'(p_edge), 32'd6);
        check("t3_release_edge", 32'(r_edge), 32'd6);
        check("t3_high_cycles", 32'(hi), 32'd20);
        check("t3_one_press", 32'(n_press - p0), 32'd1);
        check("t3_one_release", 32'(n_rel - r0), 32'd1);

        // 4: short dropout while high
        settle(1'b1);
        r0 = n_rel;
        ok = 1'b1;
        btn_in = 1'b0;
        repeat (3) begin
            tick();
            if (btn_level !== 1'b1) ok = 1'b0;
        end
        btn_in = 1'b1;
        repeat (10) begin
            tick();
            if (btn_level !== 1'b1) ok = 1'b0;
        end
        check("t4_level_high", 32'(ok), 32'd1);
        check("t4_no_release", 32'(n_rel - r0), 32'd0);

        // 5: reset mid-count restarts the count
        settle(1'b0);
        btn_in = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        p0 = n_press;
        rise_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rise_at == 0 && btn_level === 1'b1) rise_at = i;
        end
        check("t5_rise_edge", 32'(rise_at), 32'd6);
        check("t5_one_press", 32'(n_press - p0), 32'd1);

        // reset on the acceptance edge wins
        settle(1'b0);
        btn_in = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("acc_rst_level", 32'(btn_level), 32'd0);
        check("acc_rst_press", 32'(press_pulse), 32'd0);
        reset = 1'b0;

        // 6: three bouncy presses toggle the FFD three times
        btn_in = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        p0 = n_toggle;
        for (int k = 0; k < 3; k++) begin
            pat = 8'b1011_0110;
            for (int i = 7; i >= 0; i--) begin
                btn_in = pat[i];
                tick();
            end
            settle(1'b1);
            pat = 8'b0100_1001;
            for (int i = 7; i >= 0; i--) begin
                btn_in = pat[i];
                tick();
            end
            settle(1'b0);
        end
        check("t6_toggles", 32'(n_toggle - p0), 32'd3);
        check("t6_ffd_q", 32'(ff_q), 32'd1);

        // randomised bounce/hold bursts with occasional resets
        for (int b = 0; b < 600; b++) begin
            int mode, len;
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 10));
            if ($urandom_range(0, 40) == 0) reset = 1'b1;
            for (int c = 0; c < len; c++) begin
                if (mode == 0) btn_in = 1'($urandom);
                else if (c == 0) btn_in = 1'($urandom);
                tick();
                reset = 1'b0;
            end
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
